// File: rtl/hilo_muldiv.sv
// HI/LO register pair with a 32-cycle restoring divider and shift-add multiplier.
// Define HILO_FAST_MULT_EN for a single-BUSY-cycle multiply instead of the iterative one.
module hilo_muldiv #(
    parameter logic [31:0] HILO_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned OpMult  = 7;
    localparam int unsigned OpMultu = 6;
    localparam int unsigned OpDiv   = 5;
    localparam int unsigned OpDivu  = 4;
    localparam int unsigned OpMfhi  = 3;
    localparam int unsigned OpMflo  = 2;
    localparam int unsigned OpMthi  = 1;
    localparam int unsigned OpMtlo  = 0;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;      // dividend/quotient or multiplier/product-low
    logic [31:0] b_q, b_d;      // divisor or multiplicand magnitude
    logic [31:0] r_q, r_d;      // partial remainder or product-high
    logic [4:0]  cnt_q, cnt_d;
    logic        mul_q, mul_d;
    logic        neg_q, neg_d;  // negate quotient / product
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;

    logic        op_onehot;
    logic        issue;
    logic        start;
    logic        start_signed;
    logic        last_iter;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_r;
    logic [31:0] div_a;
    logic [31:0] step_a;
    logic [31:0] step_r;
    logic [63:0] prod;
    logic [63:0] prod_s;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] hi_res;
    logic [31:0] lo_res;

    // Issue decode
    assign op_onehot = (md_op != 8'd0) && ((md_op & (md_op - 8'd1)) == 8'd0);
    assign issue     = resetn && in_valid && !flush && !stall && op_onehot;
    assign start     = issue && (md_op[OpMult] || md_op[OpMultu] ||
                                 md_op[OpDiv]  || md_op[OpDivu]);
    assign start_signed = md_op[OpMult] || md_op[OpDiv];
    assign a_mag = (start_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign b_mag = (start_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Restoring divide step: shift in the next dividend bit, subtract if it fits.
    assign div_sh = {r_q, a_q[31]};
    assign div_ge = (div_sh >= {1'b0, b_q});
    assign div_r  = div_ge ? (div_sh[31:0] - b_q) : div_sh[31:0];
    assign div_a  = {a_q[30:0], div_ge};

`ifdef HILO_FAST_MULT_EN
    assign last_iter = mul_q || (cnt_q == 5'd31);
    assign step_a    = div_a;
    assign step_r    = div_r;
    assign prod      = {32'd0, a_q} * {32'd0, b_q};
`else
    logic [32:0] mul_sum;
    logic [31:0] mul_r;
    logic [31:0] mul_a;

    // Shift-add step: add multiplicand on multiplier LSB, shift {r,a} right.
    assign mul_sum   = {1'b0, r_q} + (a_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_r     = mul_sum[32:1];
    assign mul_a     = {mul_sum[0], a_q[31:1]};
    assign last_iter = (cnt_q == 5'd31);
    assign step_a    = mul_q ? mul_a : div_a;
    assign step_r    = mul_q ? mul_r : div_r;
    assign prod      = {mul_r, mul_a};
`endif

    // Sign correction of the final step's result
    always_comb begin
        prod_s = neg_q ? (64'd0 - prod) : prod;
        quo    = neg_q ? (32'd0 - div_a) : div_a;
        rem    = rneg_q ? (32'd0 - div_r) : div_r;
        if (mul_q) begin
            hi_res = prod_s[63:32];
            lo_res = prod_s[31:0];
        end else begin
            hi_res = rem;
            lo_res = dz_q ? 32'hFFFF_FFFF : quo;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StBusy;
            StBusy:  if (flush || last_iter) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy  = (state_q == StBusy);
        stall = in_valid && (md_op != 8'd0) && (state_q == StBusy);
    end

    // Datapath next state
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        mul_d  = mul_q;
        neg_d  = neg_q;
        rneg_d = rneg_q;
        dz_d   = dz_q;
        if (issue && md_op[OpMthi]) hi_d = src_a;
        if (issue && md_op[OpMtlo]) lo_d = src_a;
        if (start) begin
            a_d    = a_mag;
            b_d    = b_mag;
            r_d    = 32'd0;
            cnt_d  = 5'd0;
            mul_d  = md_op[OpMult] || md_op[OpMultu];
            neg_d  = start_signed && (src_a[31] ^ src_b[31]);
            rneg_d = start_signed && src_a[31];
            dz_d   = (src_b == 32'd0);
        end else if (state_q == StBusy) begin
            if (flush) begin
                cnt_d = 5'd0;
            end else if (last_iter) begin
                hi_d  = hi_res;
                lo_d  = lo_res;
                cnt_d = 5'd0;
            end else begin
                a_d   = step_a;
                r_d   = step_r;
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q   <= HILO_RST;
            lo_q   <= HILO_RST;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            r_q    <= 32'd0;
            cnt_q  <= 5'd0;
            mul_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            mul_q  <= mul_d;
            neg_q  <= neg_d;
            rneg_q <= rneg_d;
            dz_q   <= dz_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (issue && md_op[OpMfhi]) begin
            rdata = hi_q;
        end else if (issue && md_op[OpMflo]) begin
            rdata = lo_q;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 Parameter HILO_RST, 32'h0000_0000: reset value of the HI and LO registers.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 Port in_valid, input, 1: execute-stage instruction valid.
REQ-005 Port md_op, input, 8: decoded one-hot {MULT,MULTU,DIV,DIVU,MFHI,MFLO,MTHI,MTLO} (bit 7 to bit 0), same order as the decode ALU-control low bits.
REQ-006 Port src_a / src_b, input, 32 each: rs / rt operands, already forwarded.
REQ-007 Port flush, input, 1: exception or ERET cancel of the execute stage.
REQ-008 Port stall, output, 1: pipeline interlock request.
REQ-009 Port busy, output, 1: multi-cycle operation in flight.
REQ-010 Port rdata, output, 32: MFHI/MFLO result.
REQ-011 Port hi / lo, output, 32 each: current architectural HI/LO registers.

Function
REQ-012 States SHALL be IDLE and BUSY; busy = (state == BUSY).
REQ-013 Issue SHALL occur in cycle T when in_valid & !flush & !stall and md_op is exactly one-hot; a non-one-hot md_op SHALL be a no-op.
REQ-014 MULT/MULTU/DIV/DIVU issue SHALL latch src_a, src_b and the op at the end of T, then enter BUSY in T+1; issue itself SHALL NOT assert stall.
REQ-015 DIV/DIVU SHALL use a radix-2 restoring iteration for 32 BUSY cycles (T+1..T+32); HI/LO SHALL update at the edge ending T+32, with state IDLE in T+33.
REQ-016 Divide results SHALL be LO = quotient, HI = remainder.
REQ-017 Signed divide SHALL operate on magnitudes; the quotient sign SHALL be a^b and the remainder sign SHALL follow the dividend.
REQ-018 Divide by zero SHALL raise no exception and SHALL produce LO = 32'hFFFF_FFFF, HI = src_a, for both signed and unsigned forms.
REQ-019 MULT/MULTU SHALL write the full 64-bit signed/unsigned product as {HI,LO}; latency is per REQ-026.
REQ-020 stall SHALL equal in_valid & (md_op != 0) & busy; any HI/LO access during BUSY is interlocked and re-presented by upstream.
REQ-021 MTHI/MTLO SHALL write src_a into HI/LO at the end of the issue cycle.
REQ-022 MFHI/MFLO SHALL drive rdata = hi/lo combinationally in the issue cycle; otherwise rdata = 0.
REQ-023 flush SHALL move BUSY to IDLE at the next edge and discard the partial result, leaving HI/LO unchanged; flush with in_valid SHALL block issue (flush wins).
REQ-024 An issue coinciding with the completion edge is impossible by construction, because stall is high throughout BUSY.

Reset
REQ-025 On resetn low, regardless of clk or any in-flight operation, the block SHALL force state = IDLE, busy = 0, stall = 0, rdata = 0, hi = lo = HILO_RST and the iteration counter = 0.

Configuration
REQ-026 Macro HILO_FAST_MULT_EN controls multiply latency:
- Defined: multiply SHALL spend 1 BUSY cycle (T+1) and write HI/LO at the edge ending T+1.
- Undefined: multiply SHALL use 32-cycle shift-add iteration with timing identical to divide (REQ-015); signed multiply uses magnitudes plus sign correction.

Verification
REQ-027 MULT src_a=32'hFFFF_FFFD, src_b=5 -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFF1 after 1 cycle (macro defined) or 32 cycles (macro undefined).
REQ-028 DIVU 100/7 -> LO=14, HI=2; busy high exactly 32 cycles.
REQ-029 DIV -7/2 -> LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF; DIV 9/0 -> LO=32'hFFFF_FFFF, HI=9.
REQ-030 DIVU issued, then MFLO presented at T+1 -> stall high in T+1..T+32; rdata = quotient in T+33.
REQ-031 flush at T+10 of a DIV after MTHI 32'h1234 -> busy low from T+11, HI stays 32'h1234; resetn low at T+5 of a DIV -> hi=lo=HILO_RST and busy=0 immediately.
